// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage in-order pipeline: load-use interlock,
// taken-branch flush, data-memory wait with timeout fault, and stall accounting.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             id_ex_le,
  output logic             ex_mem_le,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               mem_stall;
  logic               load_use;
  logic [4:0]         src_reg [2];
  logic [1:0]         src_used;
  logic [1:0]         src_hit;

  assign src_reg[0]  = id_rs;
  assign src_reg[1]  = id_rt;
  assign src_used[0] = id_uses_rs;
  assign src_used[1] = id_uses_rt;

  // One comparator per source operand against the load destination in EX.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = src_used[gi] & (src_reg[gi] == ex_rd);
    end
  endgenerate

  assign mem_stall = mem_req & ~mem_ready;
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use  = ex_load & (ex_rd != 5'd0) & (|src_hit);

  always_comb begin
    pc_le         = 1'b0;
    if_id_le      = 1'b0;
    id_ex_le      = 1'b0;
    ex_mem_le     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (reset || state_q == FAULT) begin
      pc_le = 1'b0;
    end else if (mem_stall) begin
      mem_wb_bubble = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, let the load advance and insert one bubble behind it.
      id_ex_le     = 1'b1;
      ex_mem_le    = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_le       = 1'b1;
      if_id_le    = 1'b1;
      id_ex_le    = 1'b1;
      ex_mem_le   = 1'b1;
      if_id_flush = branch_taken;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    fault_d     = fault_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
    if (!pc_le && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      fault_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      fault_q     <= fault_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fault     = fault_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed literal checks followed by random
// stimulus compared every cycle against a priority-rule model.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_rd = '0;
  logic             id_uses_rs = 0, id_uses_rt = 0, ex_load = 0;
  logic             branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic             pc_le, if_id_le, id_ex_le, ex_mem_le;
  logic             if_id_flush, id_ex_bubble, mem_wb_bubble, fault;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_load(ex_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_le(pc_le), .if_id_le(if_id_le), .id_ex_le(id_ex_le), .ex_mem_le(ex_mem_le),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
    .fault(fault), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: fault flag, length of the current run of memory-stall cycles, stall total.
  bit m_fault = 0;
  int m_run   = 0;
  int m_cnt   = 0;

  // Expected {pc_le, if_id_le, id_ex_le, ex_mem_le, if_id_flush, id_ex_bubble, mem_wb_bubble}.
  function automatic logic [6:0] model_outs();
    bit ms, lu;
    ms = mem_req && !mem_ready;
    lu = ex_load && ex_rd != 0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (reset || m_fault) return 7'b0000_000;
    if (ms)               return 7'b0000_001;
    if (lu)               return 7'b0011_010;
    if (branch_taken)     return 7'b1111_100;
    return 7'b1111_000;
  endfunction

  always @(posedge clk) begin
    logic [6:0] o;
    o = model_outs();
    if (reset) begin
      m_fault <= 0; m_run <= 0; m_cnt <= 0;
    end else begin
      if (!o[6]) m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (!m_fault) begin
        if (mem_req && !mem_ready) begin
          m_run <= m_run + 1;
          if (m_run + 1 > MEM_TIMEOUT) m_fault <= 1;
        end else begin
          m_run <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] o;
    o = model_outs();
    chk("cmp_pc_le",         int'(pc_le),         int'(o[6]));
    chk("cmp_if_id_le",      int'(if_id_le),      int'(o[5]));
    chk("cmp_id_ex_le",      int'(id_ex_le),      int'(o[4]));
    chk("cmp_ex_mem_le",     int'(ex_mem_le),     int'(o[3]));
    chk("cmp_if_id_flush",   int'(if_id_flush),   int'(o[2]));
    chk("cmp_id_ex_bubble",  int'(id_ex_bubble),  int'(o[1]));
    chk("cmp_mem_wb_bubble", int'(mem_wb_bubble), int'(o[0]));
    chk("cmp_fault",         int'(fault),         int'(m_fault));
    chk("cmp_stall_cnt",     int'(stall_cnt),     m_cnt);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_load = 0; ex_rd = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use_in();
    ex_load = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
  endtask

  initial begin
    int burst;
    idle();
    reset = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst_pc_le", int'(pc_le), 0);
    chk("rst_if_id_le", int'(if_id_le), 0);
    tick(); reset = 0;
    @(negedge clk);
    chk("rst_fault", int'(fault), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_normal_pc_le", int'(pc_le), 1);

    // Load-use: one bubble, one stall cycle.
    tick(); load_use_in();
    @(negedge clk);
    chk("lu_pc_le", int'(pc_le), 0);
    chk("lu_if_id_le", int'(if_id_le), 0);
    chk("lu_id_ex_bubble", int'(id_ex_bubble), 1);
    chk("lu_ex_mem_le", int'(ex_mem_le), 1);
    tick(); idle();
    @(negedge clk);
    chk("lu_after_pc_le", int'(pc_le), 1);
    chk("lu_after_cnt", int'(stall_cnt), 1);

    // Taken branch: flush one slot, no stall.
    tick(); branch_taken = 1;
    @(negedge clk);
    chk("br_flush", int'(if_id_flush), 1);
    chk("br_pc_le", int'(pc_le), 1);
    tick(); idle();
    @(negedge clk);
    chk("br_after_flush", int'(if_id_flush), 0);
    chk("br_cnt", int'(stall_cnt), 1);

    // Three memory-wait cycles then completion.
    for (int i = 0; i < 3; i++) begin
      tick(); mem_req = 1; mem_ready = 0;
      @(negedge clk);
      chk("mw_pc_le", int'(pc_le), 0);
      chk("mw_bubble", int'(mem_wb_bubble), 1);
    end
    tick(); mem_ready = 1;
    @(negedge clk);
    chk("mw_done_pc_le", int'(pc_le), 1);
    chk("mw_done_bubble", int'(mem_wb_bubble), 0);
    chk("mw_cnt", int'(stall_cnt), 4);

    // All three conditions at once, then peel them off one by one.
    tick(); load_use_in(); branch_taken = 1; mem_req = 1; mem_ready = 0;
    @(negedge clk);
    chk("all_mwb", int'(mem_wb_bubble), 1);
    chk("all_flush", int'(if_id_flush), 0);
    chk("all_idexb", int'(id_ex_bubble), 0);
    tick(); mem_ready = 1;
    @(negedge clk);
    chk("lubr_idexb", int'(id_ex_bubble), 1);
    chk("lubr_flush", int'(if_id_flush), 0);
    chk("lubr_cnt", int'(stall_cnt), 5);
    tick(); ex_load = 0;
    @(negedge clk);
    chk("br2_flush", int'(if_id_flush), 1);
    chk("br2_cnt", int'(stall_cnt), 6);
    tick(); idle(); ex_load = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    @(negedge clk);
    chk("r0_pc_le", int'(pc_le), 1);
    chk("r0_idexb", int'(id_ex_bubble), 0);

    // Timeout into FAULT, saturation, then recovery by reset.
    tick(); idle(); reset = 1;
    tick(); reset = 0; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("to_fault_low", int'(fault), 0);
      tick();
    end
    @(negedge clk);
    chk("to_fault", int'(fault), 1);
    chk("to_pc_le", int'(pc_le), 0);
    chk("to_mwb", int'(mem_wb_bubble), 0);
    chk("to_cnt", int'(stall_cnt), 9);
    tick(); mem_req = 0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("sat_cnt", int'(stall_cnt), CNT_MAX);
    chk("fault_hold", int'(fault), 1);
    chk("fault_ifid", int'(if_id_le), 0);
    tick(); reset = 1;
    tick(); reset = 0;
    @(negedge clk);
    chk("rec_fault", int'(fault), 0);
    chk("rec_cnt", int'(stall_cnt), 0);
    chk("rec_pc_le", int'(pc_le), 1);

    // Random phase.
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      tick();
      reset        = ($urandom_range(0, 59) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_load      = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 3) == 0);
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(5, 14);
      if (burst > 0) begin
        mem_req = 1; mem_ready = 0; burst--;
      end else begin
        mem_req   = ($urandom_range(0, 2) == 0);
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
    tick(); idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
